mem_bist: RTL

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist_pkg.sv | 45 ++++
 rtl/mem_bist_addr_gen.sv | 33 +++
 rtl/mem_bist.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types for the March C- subset BIST: controller states, march phases
// and the per-phase data patterns.
package mem_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_M0_W,
      ST_M1_R,
      ST_M1_W,
      ST_M2_R,
      ST_M2_W,
      ST_M3_R,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      PH_M0,
      PH_M1,
      PH_M2,
      PH_M3
   } phase_e;

   // Patterns are replicated to DATA_W by the user.
   localparam logic PAT_ZERO_BIT = 1'b0;
   localparam logic PAT_ONE_BIT  = 1'b1;

   function automatic phase_e state_phase(input state_e s);
      case (s)
         ST_M1_R, ST_M1_W: return PH_M1;
         ST_M2_R, ST_M2_W: return PH_M2;
         ST_M3_R:          return PH_M3;
         default:          return PH_M0;
      endcase
   endfunction

   // Only M2 expects ones on reads; only M1 writes ones.
   function automatic logic read_pat_bit(input phase_e p);
      return (p == PH_M2) ? PAT_ONE_BIT : PAT_ZERO_BIT;
   endfunction

   function automatic logic write_pat_bit(input phase_e p);
      return (p == PH_M1) ? PAT_ONE_BIT : PAT_ZERO_BIT;
   endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Up/down address counter for the march elements, with clear, load-max and
// terminal-address flags.
module mem_bist_addr_gen #(
   parameter int ADDR_W = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_load_max,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_first,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_addr;

   // Increment from all-ones wraps to zero, which is exactly the ascending
   // hand-off between elements.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)        r_addr <= '0;
      else if (i_clr)      r_addr <= '0;
      else if (i_load_max) r_addr <= '1;
      else if (i_inc)      r_addr <= r_addr + ADDR_W'(1);
      else if (i_dec)      r_addr <= r_addr - ADDR_W'(1);
   end

   assign o_addr  = r_addr;
   assign o_first = (r_addr == '0);
   assign o_last  = (r_addr == '1);

endmodule

// File: rtl/mem_bist.sv
// March C- subset BIST controller (w0 up; r0,w1 up; r1,w0 down; r0 up).
// Drives an external SRAM and stops at the first read mismatch.
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [DATA_W-1:0] o_fail_exp,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_din,
   input  logic [DATA_W-1:0] i_mem_dout
);

   state_e            r_state;
   state_e            w_next;
   phase_e            w_phase;
   logic [ADDR_W-1:0] w_addr;
   logic              w_first;
   logic              w_last;
   logic              w_accept;
   logic              w_rd;
   logic [DATA_W-1:0] w_exp;
   logic              w_mismatch;
   logic              w_clr;
   logic              w_load_max;
   logic              w_inc;
   logic              w_dec;
   logic              r_done;
   logic              r_pass;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [DATA_W-1:0] r_fail_exp;

   mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (w_clr),
      .i_load_max (w_load_max),
      .i_inc      (w_inc),
      .i_dec      (w_dec),
      .o_addr     (w_addr),
      .o_first    (w_first),
      .o_last     (w_last)
   );

   assign w_phase    = state_phase(r_state);
   assign w_accept   = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_rd       = (r_state == ST_M1_R) || (r_state == ST_M2_R) || (r_state == ST_M3_R);
   assign w_exp      = {DATA_W{read_pat_bit(w_phase)}};
   assign w_mismatch = w_rd && (i_mem_dout != w_exp);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (i_start) w_next = ST_M0_W;
         ST_M0_W:          if (w_last)  w_next = ST_M1_R;
         ST_M1_R:          w_next = w_mismatch ? ST_DONE : ST_M1_W;
         ST_M1_W:          w_next = w_last ? ST_M2_R : ST_M1_R;
         ST_M2_R:          w_next = w_mismatch ? ST_DONE : ST_M2_W;
         ST_M2_W:          w_next = w_first ? ST_M3_R : ST_M2_R;
         ST_M3_R:          w_next = (w_mismatch || w_last) ? ST_DONE : ST_M3_R;
         default:          w_next = ST_IDLE;
      endcase
   end

   // Counter stays put on the abort/finish edges so the last address is held.
   always_comb begin
      o_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
      o_mem_we   = (r_state == ST_M0_W) || (r_state == ST_M1_W) || (r_state == ST_M2_W);
      o_mem_din  = o_mem_we ? {DATA_W{write_pat_bit(w_phase)}} : '0;
      w_clr      = w_accept || (r_state == ST_M2_W && w_first);
      w_load_max = (r_state == ST_M1_W) && w_last;
      w_inc      = (r_state == ST_M0_W) ||
                   (r_state == ST_M1_W && !w_last) ||
                   (r_state == ST_M3_R && !w_last && !w_mismatch);
      w_dec      = (r_state == ST_M2_W) && !w_first;
   end

   // Failure info is only rewritten by a mismatch, so a clean run leaves it intact.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_exp  <= '0;
      end else if (w_accept) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else if (w_mismatch) begin
         r_done      <= 1'b1;
         r_pass      <= 1'b0;
         r_fail_addr <= w_addr;
         r_fail_exp  <= w_exp;
      end else if (r_state == ST_M3_R && w_last) begin
         r_done <= 1'b1;
         r_pass <= 1'b1;
      end
   end

   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_exp  = r_fail_exp;
   assign o_mem_addr  = w_addr;

endmodule
